// File: rtl/bcd_timer_if.sv
// bcd_timer_if: button/preset inputs and count/status outputs of bcd_timer_ctrl.
//   btn_start, btn_mode, btn_clear : level buttons, synchronous to clk
//   preset1, preset0               : preset tens/ones digits (values > 9 read as 9)
//   BCD1, BCD0                     : registered count digits
//   dir                            : 1 = count up, 0 = count down
//   state                          : IDLE=00, RUN=01, PAUSE=10, DONE=11 (FSM state, visible for checkers)
//   cout                           : one-cycle pulse in the first DONE cycle
//   alarm                          : high for ALARM_CYCLES cycles from the first DONE cycle
// Handshake: there is no valid/ready pair; inputs are sampled on every rising
// clk edge and every output is a register that is valid one edge after the
// input that caused it.
interface bcd_timer_if;
  logic       btn_start;
  logic       btn_mode;
  logic       btn_clear;
  logic [3:0] preset1;
  logic [3:0] preset0;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       dir;
  logic [1:0] state;
  logic       cout;
  logic       alarm;

  modport master (
    output btn_start, btn_mode, btn_clear, preset1, preset0,
    input  BCD1, BCD0, dir, state, cout, alarm
  );

  modport slave (
    input  btn_start, btn_mode, btn_clear, preset1, preset0,
    output BCD1, BCD0, dir, state, cout, alarm
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: two-digit BCD interval timer with a start/pause/done FSM.
//   clk   : rising-edge system clock
//   reset : asynchronous, active-low reset
//   bus   : bcd_timer_if.slave (buttons and presets in, count/status out)
// Parameters:
//   TICK_DIV     : clock cycles per count step while running (1..255)
//   ALARM_CYCLES : cycles alarm stays high after entering DONE (1..255)
module bcd_timer_ctrl #(
  parameter int unsigned TICK_DIV     = 2,
  parameter int unsigned ALARM_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  bcd_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [7:0] LP_TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0] LP_ALARM_LAST = 8'(ALARM_CYCLES - 1);

  state_t     r_state, w_state_nx;
  logic [3:0] r_bcd1, r_bcd0, w_bcd1_nx, w_bcd0_nx;
  logic [3:0] r_term1, r_term0, w_term1_nx, w_term0_nx;
  logic       r_dir, w_dir_nx;
  logic [7:0] r_presc, w_presc_nx;
  logic       r_cout, w_cout_nx;
  logic       r_alarm, w_alarm_nx;
  logic [7:0] r_alarm_cnt, w_alarm_cnt_nx;
  logic       r_start_q, r_mode_q, r_clear_q;

  logic       w_start_ev, w_mode_ev, w_clear_ev;
  logic [3:0] w_p1, w_p0;
  logic [3:0] w_step1, w_step0;
  logic       w_load, w_load_dir, w_enter_done;

  assign w_start_ev = bus.btn_start & ~r_start_q;
  assign w_mode_ev  = bus.btn_mode  & ~r_mode_q;
  assign w_clear_ev = bus.btn_clear & ~r_clear_q;

  // Out-of-range preset digits saturate to 9.
  assign w_p1 = (bus.preset1 > 4'd9) ? 4'd9 : bus.preset1;
  assign w_p0 = (bus.preset0 > 4'd9) ? 4'd9 : bus.preset0;

  // Decimal +/-1 of the current count; the terminal register keeps the
  // count inside 00..99, so no tens overflow handling is needed.
  always_comb begin
    w_step1 = r_bcd1;
    w_step0 = r_bcd0;
    if (r_dir) begin
      if (r_bcd0 == 4'd9) begin
        w_step0 = 4'd0;
        w_step1 = r_bcd1 + 4'd1;
      end else begin
        w_step0 = r_bcd0 + 4'd1;
      end
    end else begin
      if (r_bcd0 == 4'd0) begin
        w_step0 = 4'd9;
        w_step1 = r_bcd1 - 4'd1;
      end else begin
        w_step0 = r_bcd0 - 4'd1;
      end
    end
  end

  // Next-state / output logic. Priority: clear > accepted mode > start > tick.
  always_comb begin
    w_state_nx     = r_state;
    w_bcd1_nx      = r_bcd1;
    w_bcd0_nx      = r_bcd0;
    w_term1_nx     = r_term1;
    w_term0_nx     = r_term0;
    w_dir_nx       = r_dir;
    w_presc_nx     = r_presc;
    w_cout_nx      = 1'b0;
    w_alarm_nx     = r_alarm;
    w_alarm_cnt_nx = r_alarm_cnt;
    w_load         = 1'b0;
    w_load_dir     = r_dir;
    w_enter_done   = 1'b0;

    // Alarm countdown runs on its own; later branches may restart or kill it.
    if (r_alarm) begin
      if (r_alarm_cnt == 8'd0) w_alarm_nx = 1'b0;
      else                     w_alarm_cnt_nx = r_alarm_cnt - 8'd1;
    end

    if (w_clear_ev) begin
      w_state_nx = S_IDLE;
      w_load     = 1'b1;
      w_presc_nx = 8'd0;
      w_alarm_nx = 1'b0;
    end else if (w_mode_ev && (r_state == S_IDLE)) begin
      w_dir_nx   = ~r_dir;
      w_load     = 1'b1;
      w_load_dir = ~r_dir;
    end else if (w_start_ev) begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if ({r_bcd1, r_bcd0} == {r_term1, r_term0}) begin
            w_enter_done = 1'b1;
          end else begin
            w_state_nx = S_RUN;
            w_presc_nx = 8'd0;
          end
        end
        S_RUN:   w_state_nx = S_PAUSE;
        default: ;
      endcase
    end else if (r_state == S_RUN) begin
      if (r_presc == LP_TICK_LAST) begin
        w_presc_nx = 8'd0;
        w_bcd1_nx  = w_step1;
        w_bcd0_nx  = w_step0;
        if ({w_step1, w_step0} == {r_term1, r_term0}) w_enter_done = 1'b1;
      end else begin
        w_presc_nx = r_presc + 8'd1;
      end
    end

    if (w_load) begin
      if (w_load_dir) begin
        w_bcd1_nx  = 4'd0;
        w_bcd0_nx  = 4'd0;
        w_term1_nx = w_p1;
        w_term0_nx = w_p0;
      end else begin
        w_bcd1_nx  = w_p1;
        w_bcd0_nx  = w_p0;
        w_term1_nx = 4'd0;
        w_term0_nx = 4'd0;
      end
    end

    if (w_enter_done) begin
      w_state_nx     = S_DONE;
      w_cout_nx      = 1'b1;
      w_alarm_nx     = 1'b1;
      w_alarm_cnt_nx = LP_ALARM_LAST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bcd1      <= 4'd0;
      r_bcd0      <= 4'd0;
      r_term1     <= 4'd0;
      r_term0     <= 4'd0;
      r_dir       <= 1'b1;
      r_presc     <= 8'd0;
      r_cout      <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= 8'd0;
      r_start_q   <= 1'b0;
      r_mode_q    <= 1'b0;
      r_clear_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bcd1      <= w_bcd1_nx;
      r_bcd0      <= w_bcd0_nx;
      r_term1     <= w_term1_nx;
      r_term0     <= w_term0_nx;
      r_dir       <= w_dir_nx;
      r_presc     <= w_presc_nx;
      r_cout      <= w_cout_nx;
      r_alarm     <= w_alarm_nx;
      r_alarm_cnt <= w_alarm_cnt_nx;
      r_start_q   <= bus.btn_start;
      r_mode_q    <= bus.btn_mode;
      r_clear_q   <= bus.btn_clear;
    end
  end

  assign bus.BCD1  = r_bcd1;
  assign bus.BCD0  = r_bcd0;
  assign bus.dir   = r_dir;
  assign bus.state = r_state;
  assign bus.cout  = r_cout;
  assign bus.alarm = r_alarm;

endmodule
